// File: rtl/vga_spi_line_fetch.sv
// rtl/vga_spi_line_fetch.sv - per-scanline SPI ROM reader feeding a double-banked line buffer
//
// Purpose:
//   Once per displayed line, when hpos reaches H_TRIGGER, reads BYTES_PER_LINE bytes
//   for the NEXT line from an SPI flash (READ 0x03, 24-bit address, mode 0, clk/2) and
//   writes them into the bank selected by the LSB of that line number. This block is
//   the only master on the SPI bus; the pixel path reads the opposite bank.
//
// Ports:
//   clk        pixel clock
//   reset      synchronous, active-high reset
//   hpos/vpos  raster position from vga_sync
//   spi_miso   ROM serial data out
//   spi_cs_n   ROM chip select (active low)
//   spi_sclk   SPI clock, idles low
//   spi_mosi   command/address bits, MSB first; 0 during data
//   buf_we     one-cycle line-buffer write strobe
//   buf_sel    bank being written (LSB of fetched line)
//   buf_addr   byte index within the line
//   buf_data   assembled byte, MSB first
//   busy       high from the trigger edge through the DONE cycle
//   line_done  one-cycle pulse after the last byte is written
//   overrun    one-cycle pulse when a trigger arrives while busy

module vga_spi_line_fetch #(
  parameter int unsigned H_TRIGGER      = 640,
  parameter int unsigned V_VIEW         = 480,
  parameter int unsigned V_MAX          = 524,
  parameter int unsigned BYTES_PER_LINE = 16,
  parameter logic [23:0] BASE_ADDR      = 24'h000000,
  parameter int unsigned BUF_AW         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              spi_miso,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              buf_we,
  output logic              buf_sel,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output logic              busy,
  output logic              line_done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [BUF_AW-1:0] LAST_BYTE = BUF_AW'(BYTES_PER_LINE - 1);

  state_t state_q, state_d;

  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              we_q, we_d;
  logic              sel_q, sel_d;
  logic [BUF_AW-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;    // CMD/ADDR bit index 0..31
  logic [2:0]        dbit_cnt_q, dbit_cnt_d;  // bit index within current data byte
  logic [BUF_AW-1:0] byte_cnt_q, byte_cnt_d;  // saturates at LAST_BYTE
  logic [30:0]       shift_q, shift_d;        // command/address bits not yet on mosi
  logic [6:0]        rx_q, rx_d;              // first seven bits of the byte being received

  // Line number is one bit wider than vpos so vpos+1 can never wrap back into range.
  logic [10:0] fetch_line;
  logic        trigger;
  logic [23:0] rom_addr;
  logic [31:0] cmd_word;

  assign fetch_line = (vpos == 10'(V_MAX)) ? 11'd0 : ({1'b0, vpos} + 11'd1);
  assign trigger    = (hpos == 10'(H_TRIGGER)) && (fetch_line < 11'(V_VIEW));
  assign rom_addr   = BASE_ADDR + 24'(fetch_line) * 24'(BYTES_PER_LINE);
  assign cmd_word   = {8'h03, rom_addr};

  // sclk_q doubles as the bit phase: low means the next edge raises sclk,
  // high means the next edge completes a bit.
  logic bit_edge;
  assign bit_edge = sclk_q;

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      bit_cnt_q  <= 6'd0;
      dbit_cnt_q <= 3'd0;
      byte_cnt_q <= '0;
      shift_q    <= 31'd0;
      rx_q       <= 7'd0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      bit_cnt_q  <= bit_cnt_d;
      dbit_cnt_q <= dbit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (trigger) state_d = S_CMD;
      S_CMD:  if (bit_edge && bit_cnt_q == 6'd7) state_d = S_ADDR;
      S_ADDR: if (bit_edge && bit_cnt_q == 6'd31) state_d = S_DATA;
      S_DATA: if (bit_edge && dbit_cnt_q == 3'd7 && byte_cnt_q == LAST_BYTE) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    we_d       = 1'b0;
    sel_d      = sel_q;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovr_d      = trigger && (state_q != S_IDLE);
    bit_cnt_d  = bit_cnt_q;
    dbit_cnt_d = dbit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          cs_n_d     = 1'b0;
          sclk_d     = 1'b0;
          mosi_d     = cmd_word[31];
          shift_d    = cmd_word[30:0];
          sel_d      = fetch_line[0];
          busy_d     = 1'b1;
          bit_cnt_d  = 6'd0;
          dbit_cnt_d = 3'd0;
          byte_cnt_d = '0;
        end
      end
      S_CMD, S_ADDR: begin
        if (!bit_edge) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd31) begin
            mosi_d = 1'b0;
          end else begin
            mosi_d  = shift_q[30];
            shift_d = {shift_q[29:0], 1'b0};
          end
        end
      end
      S_DATA: begin
        if (!bit_edge) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d     = 1'b0;
          rx_d       = {rx_q[5:0], spi_miso};
          dbit_cnt_d = dbit_cnt_q + 3'd1;
          if (dbit_cnt_q == 3'd7) begin
            we_d   = 1'b1;
            addr_d = byte_cnt_q;
            data_d = {rx_q, spi_miso};
            if (byte_cnt_q == LAST_BYTE) begin
              cs_n_d = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign spi_cs_n  = cs_n_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign buf_we    = we_q;
  assign buf_sel   = sel_q;
  assign buf_addr  = addr_q;
  assign buf_data  = data_q;
  assign busy      = busy_q;
  assign line_done = done_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_vga_spi_line_fetch.sv
// tb/tb_vga_spi_line_fetch.sv - randomized self-checking bench for vga_spi_line_fetch
module tb_vga_spi_line_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hpos = 10'd0;
  logic [9:0] vpos = 10'd0;
  logic       spi_miso = 1'b0;

  logic       spi_cs_n, spi_sclk, spi_mosi, buf_we, buf_sel, busy, line_done, overrun;
  logic [3:0] buf_addr;
  logic [7:0] buf_data;

  logic       d2_cs_n, d2_sclk, d2_mosi, d2_we, d2_sel, d2_busy, d2_done, d2_ovr;
  logic [3:0] d2_addr;
  logic [7:0] d2_data;

  vga_spi_line_fetch dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .buf_we(buf_we), .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_data(buf_data),
    .busy(busy), .line_done(line_done), .overrun(overrun)
  );

  vga_spi_line_fetch #(.BASE_ADDR(24'hFFFFF0)) dut2 (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .spi_miso(spi_miso),
    .spi_cs_n(d2_cs_n), .spi_sclk(d2_sclk), .spi_mosi(d2_mosi),
    .buf_we(d2_we), .buf_sel(d2_sel), .buf_addr(d2_addr), .buf_data(d2_data),
    .busy(d2_busy), .line_done(d2_done), .overrun(d2_ovr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  logic [7:0] rom_seed;

  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    return (a[7:0] * 8'h25) ^ a[15:8] ^ a[23:16] ^ rom_seed;
  endfunction

  // Reference model: a transfer is a fixed 322-edge timeline starting at the
  // accepted trigger edge; any qualifying trigger inside it is an overrun.
  int          cyc = 0;
  int          start_cyc = 0;
  bit          have = 1'b0;
  bit          exp_ovr = 1'b0;
  int          exp_line = 0;
  int          m_line;
  logic [23:0] exp_addr = 24'd0;
  logic [23:0] exp_addr2 = 24'd0;

  initial forever begin
    @(posedge clk);
    cyc++;
    exp_ovr = 1'b0;
    if (reset) begin
      have = 1'b0;
    end else begin
      m_line = (int'(vpos) == 524) ? 0 : int'(vpos) + 1;
      if (int'(hpos) == 640 && m_line < 480) begin
        if (have && (cyc - start_cyc) <= 321) begin
          exp_ovr = 1'b1;
        end else begin
          have      = 1'b1;
          start_cyc = cyc;
          exp_line  = m_line;
          exp_addr  = 24'(m_line * 16);
          exp_addr2 = 24'(32'hFFFFF0 + m_line * 16);
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model timeline.
  int          d, j;
  logic [31:0] cmd_word;
  logic        e_cs, e_sclk, e_mosi, e_busy, e_done, e_we;

  initial forever begin
    @(negedge clk);
    d        = have ? (cyc - start_cyc) : 100000;
    cmd_word = {8'h03, exp_addr};
    e_cs     = !(d < 320);
    e_sclk   = (d < 320) && (d % 2 == 1);
    e_mosi   = (d < 64) ? cmd_word[31 - d / 2] : 1'b0;
    e_busy   = (d <= 320);
    e_done   = (d == 321);
    e_we     = (d >= 80) && (d <= 320) && ((d - 80) % 16 == 0);
    check("cs_n", 32'(spi_cs_n), 32'(e_cs));
    check("sclk", 32'(spi_sclk), 32'(e_sclk));
    check("mosi", 32'(spi_mosi), 32'(e_mosi));
    check("busy", 32'(busy), 32'(e_busy));
    check("line_done", 32'(line_done), 32'(e_done));
    check("buf_we", 32'(buf_we), 32'(e_we));
    check("overrun", 32'(overrun), 32'(exp_ovr));
    check("dut2_cs_n", 32'(d2_cs_n), 32'(e_cs));
    if (e_we) begin
      j = (d - 80) / 16;
      check("buf_addr", 32'(buf_addr), 32'(j));
      check("buf_data", 32'(buf_data), 32'(rom_byte(exp_addr + 24'(j))));
    end
    if (d <= 321) check("buf_sel", 32'(buf_sel), 32'(exp_line % 2));
  end

  // SPI ROM slave: decodes command/address from mosi on sclk rises and
  // presents data bits after each rise so the master samples on the fall.
  logic        prev_sclk = 1'b0;
  int          rises = 0;
  int          rj;
  logic [31:0] rx_cmd = 32'd0;
  logic [7:0]  tmp_byte;

  initial forever begin
    @(negedge clk);
    if (spi_cs_n) begin
      rises = 0;
    end else if (spi_sclk && !prev_sclk) begin
      if (rises < 32) begin
        rx_cmd = {rx_cmd[30:0], spi_mosi};
        if (rises == 31) check("rom_cmd_addr", rx_cmd, {8'h03, exp_addr});
      end else begin
        rj       = rises - 32;
        tmp_byte = rom_byte(rx_cmd[23:0] + 24'(rj / 8));
        spi_miso = tmp_byte[7 - (rj % 8)];
      end
      rises++;
    end
    prev_sclk = spi_sclk;
  end

  logic        prev_sclk2 = 1'b0;
  int          rises2 = 0;
  logic [31:0] rx_cmd2 = 32'd0;

  initial forever begin
    @(negedge clk);
    if (d2_cs_n) begin
      rises2 = 0;
    end else if (d2_sclk && !prev_sclk2) begin
      if (rises2 < 32) begin
        rx_cmd2 = {rx_cmd2[30:0], d2_mosi};
        if (rises2 == 31) check("dut2_cmd_addr", rx_cmd2, {8'h03, exp_addr2});
      end
      rises2++;
    end
    prev_sclk2 = d2_sclk;
  end

  // One scanline slice: hpos hits 640 at i=10 (edge T); optional extra
  // hpos=640 at T+ovr and reset pulse at T+rst.
  task automatic run_line(input int v, input int ovr, input int rst);
    for (int i = 0; i < 346; i++) begin
      @(negedge clk);
      vpos  = 10'(v);
      hpos  = 10'((630 + i) % 800);
      if (ovr != 0 && i == 10 + ovr) hpos = 10'd640;
      reset = (rst != 0 && i == 10 + rst);
    end
  endtask

  int rv, ro, rr;

  initial begin
    rom_seed = 8'($urandom);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_buf_addr", 32'(buf_addr), 32'd0);
    check("reset_buf_data", 32'(buf_data), 32'd0);
    check("reset_buf_sel", 32'(buf_sel), 32'd0);
    reset = 1'b0;

    run_line(10, 0, 0);
    run_line(524, 0, 0);
    run_line(479, 0, 0);
    run_line(500, 0, 0);
    run_line(10, 100, 0);
    run_line(10, 321, 0);
    run_line(10, 0, 150);
    run_line(10, 0, 0);
    run_line(0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      rv = int'($urandom_range(0, 524));
      ro = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 321)) : 0;
      rr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 330)) : 0;
      run_line(rv, ro, rr);
    end
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
